pix_frame_sender: RTL and testbench

Transmit side of the pixel stream consumed by `bnn`. Holds one grayscale frame in an internal buffer loaded through a simple write port. On `start`, it streams the frame to `bnn.pix` at one pixel per clock. It then waits a fixed inference latency, samples `bnn.pred` (one-hot, 10 classes) and reports the decoded digit. It sits between the host/loader logic and `bnn`, replacing hand-driven pixel stimulus in system-level runs.

---
 rtl/pix_frame_sender.sv | 136 +++++++++++++
 tb/tb_pix_frame_sender.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pix_frame_sender.sv
// Buffers one grayscale frame, streams it to bnn at one pixel per clock, then samples and decodes bnn's one-hot prediction.
// Optional macro PIX_BINARIZE_EN: stream thresholded pixels (>= THRESH -> all-ones, else 0) instead of raw values.
module pix_frame_sender #(
    parameter int NPIX     = 784,
    parameter int PIX_W    = 8,
    parameter int PRED_LAT = 4,
    parameter int THRESH   = 128
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             wr_en,
    input  logic [9:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             start,
    input  logic [9:0]       pred,
    output logic [PIX_W-1:0] pix,
    output logic             pix_vld,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [3:0]       digit,
    output logic             digit_vld,
    output logic             err
);

    localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PW = AW + 1;

    if (NPIX < 1 || NPIX > 1024 || PRED_LAT < 1 || PRED_LAT > 255 || THRESH < 0) begin : g_bad_param
        $error("pix_frame_sender: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, CAPTURE} state_t;

    state_t           state;
    logic [PW-1:0]    rd_ptr;
    logic [7:0]       cnt;
    logic [PIX_W-1:0] frame_mem [NPIX];
    logic             wr_ok;
    logic [PIX_W-1:0] first_pix;

    function automatic logic [PIX_W-1:0] shape(input logic [PIX_W-1:0] p);
`ifdef PIX_BINARIZE_EN
        return (p >= PIX_W'(THRESH)) ? '1 : '0;
`else
        return p;
`endif
    endfunction

    // Returns {err, digit}; anything but exactly one set bit is an error.
    function automatic logic [4:0] decode(input logic [9:0] p);
        logic [4:0] r;
        int         ones;
        r    = {1'b1, 4'd15};
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (p[i]) begin
                ones++;
                r = {1'b0, 4'(i)};
            end
        end
        if (ones != 1) r = {1'b1, 4'd15};
        return r;
    endfunction

    assign wr_ok = (state == IDLE) && wr_en && ({1'b0, wr_addr} < 11'(NPIX));

    always_ff @(posedge clk) begin
        if (wr_ok) frame_mem[wr_addr[AW-1:0]] <= wr_data;
    end

    // Pixel 0 leaves on the start edge, so a same-cycle write to address 0 is forwarded.
    assign first_pix = (wr_ok && wr_addr == 10'd0) ? wr_data : frame_mem[0];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            cnt       <= '0;
            pix       <= '0;
            pix_vld   <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            busy      <= 1'b0;
            digit     <= 4'd0;
            digit_vld <= 1'b0;
            err       <= 1'b0;
        end else begin
            pix       <= '0;
            pix_vld   <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            digit_vld <= 1'b0;
            case (state)
                IDLE, CAPTURE: begin
                    if (start) begin
                        state   <= STREAM;
                        pix     <= shape(first_pix);
                        pix_vld <= 1'b1;
                        sof     <= 1'b1;
                        eof     <= (NPIX == 1);
                        rd_ptr  <= PW'(1);
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (rd_ptr == PW'(NPIX)) begin
                        state <= WAIT;
                        cnt   <= 8'd1;
                    end else begin
                        pix     <= shape(frame_mem[rd_ptr[AW-1:0]]);
                        pix_vld <= 1'b1;
                        eof     <= (rd_ptr == PW'(NPIX - 1));
                        rd_ptr  <= rd_ptr + PW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == 8'(PRED_LAT)) begin
                        state        <= CAPTURE;
                        {err, digit} <= decode(pred);
                        digit_vld    <= 1'b1;
                        cnt          <= '0;
                        rd_ptr       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_frame_sender.sv
// Bench for pix_frame_sender: frame-level reference model (pixel array + popcount decode) checked cycle by cycle.
module tb_pix_frame_sender;

    localparam int NPIX     = 784;
    localparam int PIX_W    = 8;
    localparam int PRED_LAT = 4;
    localparam int THRESH   = 128;

    logic             clk;
    logic             xrst;
    logic             wr_en;
    logic [9:0]       wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             start;
    logic [9:0]       pred;
    logic [PIX_W-1:0] pix;
    logic             pix_vld;
    logic             sof;
    logic             eof;
    logic             busy;
    logic [3:0]       digit;
    logic             digit_vld;
    logic             err;

    int tests = 0;
    int fails = 0;
    logic [PIX_W-1:0] model [NPIX];

    pix_frame_sender #(
        .NPIX(NPIX), .PIX_W(PIX_W), .PRED_LAT(PRED_LAT), .THRESH(THRESH)
    ) dut (
        .clk(clk), .xrst(xrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .pred(pred), .pix(pix), .pix_vld(pix_vld), .sof(sof), .eof(eof),
        .busy(busy), .digit(digit), .digit_vld(digit_vld), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PIX_W-1:0] exp_pix(input int i);
`ifdef PIX_BINARIZE_EN
        return (model[i] >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
        return model[i];
`endif
    endfunction

    // mode 0: ramp i[7:0], 1: random, 2: 127/128 alternating
    task automatic load(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            if (mode == 0)      wr_data = 8'(i);
            else if (mode == 1) wr_data = 8'($urandom);
            else                wr_data = (i % 2 == 1) ? 8'd128 : 8'd127;
            model[i] = wr_data;
            step();
        end
        // out-of-range address must be dropped
        wr_addr = 10'd800;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        xrst = 1'b0;
        step();
        step();
        tests++;
        if (pix !== 8'd0 || pix_vld !== 1'b0 || sof !== 1'b0 || eof !== 1'b0 || busy !== 1'b0 ||
            digit_vld !== 1'b0 || err !== 1'b0 || digit !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: pix=%h vld=%b sof=%b eof=%b busy=%b dv=%b err=%b digit=%0d, want all 0",
                     pix, pix_vld, sof, eof, busy, digit_vld, err, digit);
        end
        xrst = 1'b1;
        step();
    endtask

    // One full frame; hold keeps start high so the next frame chains; midwrite pokes addr 5 while busy.
    task automatic test_frame(input logic [9:0] p, input bit hold, input bit midwrite);
        int         ones;
        logic [3:0] ed;
        logic       ee;
        ones = $countones(p);
        ed   = (ones == 1) ? 4'($clog2(p)) : 4'd15;
        ee   = (ones != 1);
        pred  = p;
        start = 1'b1;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            tests++;
            if (pix !== exp_pix(i) || pix_vld !== 1'b1 || sof !== (i == 0) || eof !== (i == NPIX - 1) ||
                busy !== 1'b1 || digit_vld !== 1'b0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL stream[%0d]: pix=%h vld=%b sof=%b eof=%b busy=%b dv=%b, want pix=%h vld=1 sof=%b eof=%b busy=1 dv=0",
                             i, pix, pix_vld, sof, eof, busy, digit_vld, exp_pix(i), (i == 0), (i == NPIX - 1));
            end
            if (i == 0) start = hold;
            if (midwrite) begin
                wr_en   = (i == 300);
                wr_addr = 10'd5;
                wr_data = 8'hAA;
            end
            step();
        end
        wr_en = 1'b0;
        for (int j = 1; j <= PRED_LAT; j++) begin
            tests++;
            if (digit_vld !== 1'b0 || busy !== 1'b1 || pix_vld !== 1'b0 || pix !== 8'd0 || eof !== 1'b0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL wait[%0d]: dv=%b busy=%b vld=%b pix=%h eof=%b, want dv=0 busy=1 vld=0 pix=0 eof=0",
                             j, digit_vld, busy, pix_vld, pix, eof);
            end
            step();
        end
        tests++;
        if (digit_vld !== 1'b1 || busy !== 1'b1 || digit !== ed || err !== ee) begin
            fails++;
            $display("FAIL capture(pred=%b): dv=%b busy=%b digit=%0d err=%b, want dv=1 busy=1 digit=%0d err=%b",
                     p, digit_vld, busy, digit, err, ed, ee);
        end
        if (!hold) begin
            pred = 10'($urandom);
            step();
            tests++;
            if (digit_vld !== 1'b0 || busy !== 1'b0 || pix_vld !== 1'b0 || digit !== ed || err !== ee) begin
                fails++;
                $display("FAIL after_capture: dv=%b busy=%b vld=%b digit=%0d err=%b, want dv=0 busy=0 vld=0 digit=%0d err=%b",
                         digit_vld, busy, pix_vld, digit, err, ed, ee);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_frame(10'b0100000000, 1'b1, 1'b1);
        test_frame(10'b0000000100, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        tests++;
        if (pix !== exp_pix(100) || pix_vld !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_pix100: pix=%h vld=%b, want pix=%h vld=1", pix, pix_vld, exp_pix(100));
        end
        #2 xrst = 1'b0;
        #1;
        tests++;
        if (pix !== 8'd0 || pix_vld !== 1'b0 || busy !== 1'b0 || sof !== 1'b0 || eof !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: pix=%h vld=%b busy=%b sof=%b eof=%b, want all 0", pix, pix_vld, busy, sof, eof);
        end
        step();
        xrst = 1'b1;
        step();
        step();
        tests++;
        if (busy !== 1'b0 || pix_vld !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: busy=%b vld=%b, want busy=0 vld=0", busy, pix_vld);
        end
        test_frame(10'b1000000000, 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [9:0] p;
        for (int n = 0; n < 4; n++) begin
            if ($urandom_range(0, 1) == 0) p = 10'(1 << $urandom_range(0, 9));
            else                           p = 10'($urandom);
            repeat ($urandom_range(0, 3)) step();
            test_frame(p, 1'b0, 1'b0);
        end
    endtask

    task automatic test_start_write();
        wr_en    = 1'b1;
        wr_addr  = 10'd0;
        wr_data  = ~model[0];
        model[0] = wr_data;
        test_frame(10'b0000010000, 1'b0, 1'b0);
    endtask

    task automatic test_binarize();
        load(2);
        test_frame(10'b0000000001, 1'b0, 1'b0);
    endtask

    initial begin
        xrst    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 10'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        pred    = 10'd0;
        test_reset();
        load(0);
        test_frame(10'b0000001000, 1'b0, 1'b0);
        test_frame(10'b0000000000, 1'b0, 1'b0);
        test_frame(10'b0000000011, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_midframe();
        load(1);
        test_random_frames();
        test_start_write();
        test_binarize();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
